// File: rtl/graph_menu_ctrl_if.sv
// rtl/graph_menu_ctrl_if.sv - button/state inputs and menu outputs of the graph-menu controller
interface graph_menu_ctrl_if #(
    parameter int NUM_ROWS = 2,
    parameter int TYPE_W   = 2,
    parameter int ROW_W    = 1
);
    logic                         state_entry;
    logic                         btnC;
    logic                         btnL;
    logic                         btnR;
    logic                         btnU;
    logic                         btnD;
    logic [ROW_W-1:0]             cursor_pos;
    logic [NUM_ROWS*TYPE_W-1:0]   row_types;
    logic                         menu_confirmed;
    logic                         locked;

    modport master (
        output state_entry, btnC, btnL, btnR, btnU, btnD,
        input  cursor_pos, row_types, menu_confirmed, locked
    );

    modport slave (
        input  state_entry, btnC, btnL, btnR, btnU, btnD,
        output cursor_pos, row_types, menu_confirmed, locked
    );
endinterface

// File: rtl/graph_menu_ctrl.sv
// rtl/graph_menu_ctrl.sv - graph-selection menu: wrapping cursor, per-row type codes, L/R hold-to-repeat, confirm lock
module graph_menu_ctrl #(
    parameter int NUM_ROWS      = 2,
    parameter int NUM_TYPES     = 3,
    parameter int TYPE_W        = 2,
    parameter int ROW_W         = 1,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    graph_menu_ctrl_if.slave  bus
);
    localparam int MAX_RP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W  = $clog2(MAX_RP);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

    rpt_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       dir_q, dir_d;       // 1 = right
    logic [4:0]                 btn, btn_prev_q, btn_edge;
    logic [ROW_W-1:0]           cursor_q, cursor_d;
    logic [NUM_ROWS*TYPE_W-1:0] types_q, types_d;
    logic                       confirmed_q, confirmed_d;
    logic                       locked_q, locked_d;
    logic                       active, l_alone, r_alone, held_alone, at_terminal;
    logic                       step_r, step_l;
    logic [31:0]                type_lsb;
    logic [TYPE_W-1:0]          cur_type, new_type;

    // {C, L, R, U, D}
    assign btn        = {bus.btnC, bus.btnL, bus.btnR, bus.btnU, bus.btnD};
    assign btn_edge   = btn & ~btn_prev_q;
    assign active     = ~bus.state_entry & ~locked_q;
    assign l_alone    = bus.btnL & ~bus.btnR;
    assign r_alone    = bus.btnR & ~bus.btnL;
    assign held_alone = dir_q ? r_alone : l_alone;
    assign at_terminal = (state_q == DELAY)  ? (cnt_q == CNT_W'(REPEAT_DELAY - 1)) :
                         (state_q == REPEAT) ? (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (!active) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_edge[2] && !bus.btnL) begin
                        state_d = DELAY;
                        cnt_d   = '0;
                        dir_d   = 1'b1;
                    end else if (btn_edge[3] && !bus.btnR) begin
                        state_d = DELAY;
                        cnt_d   = '0;
                        dir_d   = 1'b0;
                    end
                end
                DELAY, REPEAT: begin
                    if (!held_alone) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (at_terminal) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        step_r = 1'b0;
        step_l = 1'b0;
        if (active) begin
            if (state_q == IDLE) begin
                step_r = btn_edge[2] & ~bus.btnL;
                step_l = btn_edge[3] & ~bus.btnR;
            end else if (held_alone && at_terminal) begin
                step_r = dir_q;
                step_l = ~dir_q;
            end
        end
    end

    // Type step targets the row under the cursor as it was before this cycle's move
    assign type_lsb = 32'(cursor_q) * TYPE_W;
    assign cur_type = types_q[type_lsb +: TYPE_W];

    always_comb begin
        if (32'(cur_type) >= NUM_TYPES)
            new_type = '0;
        else if (step_r)
            new_type = (32'(cur_type) == NUM_TYPES - 1) ? '0 : cur_type + TYPE_W'(1);
        else
            new_type = (cur_type == '0) ? TYPE_W'(NUM_TYPES - 1) : cur_type - TYPE_W'(1);
    end

    always_comb begin
        types_d     = types_q;
        cursor_d    = cursor_q;
        confirmed_d = 1'b0;
        locked_d    = locked_q;
        if (bus.state_entry) begin
            locked_d = 1'b0;
        end else if (active) begin
            if (step_r || step_l)
                types_d[type_lsb +: TYPE_W] = new_type;
            if (btn_edge[1] && !btn_edge[0])
                cursor_d = (cursor_q == '0) ? ROW_W'(NUM_ROWS - 1) : cursor_q - ROW_W'(1);
            else if (btn_edge[0] && !btn_edge[1])
                cursor_d = (cursor_q == ROW_W'(NUM_ROWS - 1)) ? '0 : cursor_q + ROW_W'(1);
            if (btn_edge[4]) begin
                confirmed_d = 1'b1;
                locked_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev_q  <= '0;
            cursor_q    <= '0;
            types_q     <= '0;
            confirmed_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            btn_prev_q  <= btn;
            cursor_q    <= cursor_d;
            types_q     <= types_d;
            confirmed_q <= confirmed_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.cursor_pos     = cursor_q;
    assign bus.row_types      = types_q;
    assign bus.menu_confirmed = confirmed_q;
    assign bus.locked         = locked_q;
endmodule

// File: tb/tb_graph_menu_ctrl.sv
// tb/tb_graph_menu_ctrl.sv - scoreboard bench for graph_menu_ctrl against a hold-length reference model
module tb_graph_menu_ctrl;
    localparam int NR = 3;
    localparam int NT = 3;
    localparam int TW = 2;
    localparam int RW = 2;
    localparam int RD = 4;
    localparam int RP = 3;

    localparam logic [4:0] BC = 5'b10000;
    localparam logic [4:0] BL = 5'b01000;
    localparam logic [4:0] BR = 5'b00100;
    localparam logic [4:0] BU = 5'b00010;
    localparam logic [4:0] BD = 5'b00001;

    typedef struct packed {
        logic [RW-1:0]    cur;
        logic [NR*TW-1:0] types;
        logic             conf;
        logic             lk;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    graph_menu_ctrl_if #(.NUM_ROWS(NR), .TYPE_W(TW), .ROW_W(RW)) bus();

    graph_menu_ctrl #(
        .NUM_ROWS(NR), .NUM_TYPES(NT), .TYPE_W(TW), .ROW_W(RW),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;
    exp_t exp_q[$];

    // Reference model: the repeat behaviour is tracked as "cycles held alone since the press edge"
    int         m_cur;
    int         m_types[NR];
    bit         m_locked;
    bit         m_conf;
    logic [4:0] m_prev;
    int         hold_dir;   // 0 none, 1 right, 2 left
    int         hold_len;

    task automatic model(input bit rst, input bit se, input logic [4:0] b);
        logic [4:0] e;
        bit c, l, r;
        int sdir;
        if (rst) begin
            m_cur = 0; m_locked = 0; m_conf = 0; m_prev = '0; hold_dir = 0; hold_len = 0;
            for (int i = 0; i < NR; i++) m_types[i] = 0;
            return;
        end
        e = b & ~m_prev;
        m_prev = b;
        c = b[4]; l = b[3]; r = b[2];
        m_conf = 0;
        if (se) begin
            m_locked = 0;
            hold_dir = 0;
        end else if (m_locked) begin
            hold_dir = 0;
        end else begin
            sdir = 0;
            if (hold_dir != 0) begin
                if ((hold_dir == 1 && r && !l) || (hold_dir == 2 && l && !r)) begin
                    hold_len++;
                    if (hold_len == RD || (hold_len > RD && (hold_len - RD) % RP == 0))
                        sdir = hold_dir;
                end else begin
                    hold_dir = 0;
                end
            end else if (e[2] && !l) begin
                hold_dir = 1; hold_len = 0; sdir = 1;
            end else if (e[3] && !r) begin
                hold_dir = 2; hold_len = 0; sdir = 2;
            end
            if (sdir == 1) m_types[m_cur] = (m_types[m_cur] + 1) % NT;
            if (sdir == 2) m_types[m_cur] = (m_types[m_cur] + NT - 1) % NT;
            if (e[1] && !e[0]) m_cur = (m_cur + NR - 1) % NR;
            else if (e[0] && !e[1]) m_cur = (m_cur + 1) % NR;
            if (e[4] && c) begin
                m_conf = 1;
                m_locked = 1;
            end
        end
    endtask

    function automatic exp_t pack_model();
        exp_t x;
        x.cur = RW'(m_cur);
        for (int i = 0; i < NR; i++) x.types[i*TW +: TW] = TW'(m_types[i]);
        x.conf = m_conf;
        x.lk   = m_locked;
        return x;
    endfunction

    task automatic cyc(input bit rst, input bit se, input logic [4:0] b);
        @(negedge clk);
        reset = rst;
        bus.state_entry = se;
        {bus.btnC, bus.btnL, bus.btnR, bus.btnU, bus.btnD} = b;
        model(rst, se, b);
        exp_q.push_back(pack_model());
    endtask

    task automatic press(input logic [4:0] b);
        cyc(0, 0, b);
        cyc(0, 0, '0);
    endtask

    // Monitor: one registered snapshot per clock, compared against the oldest expectation
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.cursor_pos, bus.row_types, bus.menu_confirmed, bus.locked};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got cur=%0d types=%h conf=%b locked=%b, expected cur=%0d types=%h conf=%b locked=%b",
                             n_cycle, g.cur, g.types, g.conf, g.lk, e.cur, e.types, e.conf, e.lk);
                end
            end
        end
    end

    initial begin
        logic [4:0] b;
        bit se, rst;
        bus.state_entry = 0;
        {bus.btnC, bus.btnL, bus.btnR, bus.btnU, bus.btnD} = '0;
        model(1, 0, '0);

        cyc(1, 0, '0);
        cyc(1, 0, '0);
        cyc(0, 0, '0);
        repeat (3) press(BD);
        press(BU);
        press(BD);
        repeat (3) press(BR);
        press(BL);

        repeat (12) cyc(0, 0, BR);
        repeat (5) cyc(0, 0, '0);

        cyc(0, 0, BR);
        cyc(0, 0, '0);
        repeat (2) cyc(0, 0, BR);
        cyc(0, 1, BR);
        repeat (2) cyc(0, 0, BR);
        cyc(0, 0, '0);
        press(BC);
        press(BD);
        press(BR);
        cyc(0, 1, '0);
        cyc(0, 0, '0);

        press(BU | BD);
        while (m_cur != 0) press(BD);
        press(BR | BD);
        press(BL | BR);

        repeat (10) cyc(0, 0, BR);
        @(negedge clk);
        reset = 1;
        #1;
        n_checks++;
        if ({bus.cursor_pos, bus.row_types, bus.menu_confirmed, bus.locked} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got cur=%0d types=%h conf=%b locked=%b, expected all zero",
                     bus.cursor_pos, bus.row_types, bus.menu_confirmed, bus.locked);
        end
        model(1, 0, BR);
        exp_q.push_back(pack_model());
        cyc(1, 0, BR);
        repeat (3) cyc(0, 0, BR);
        cyc(0, 0, '0);

        b = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 5; k++) begin
                if (k == 4) begin
                    if ($urandom_range(0, 29) == 0) b[k] = ~b[k];
                end else if (k == 2 || k == 3) begin
                    if ($urandom_range(0, 11) == 0) b[k] = ~b[k];
                end else if ($urandom_range(0, 5) == 0) begin
                    b[k] = ~b[k];
                end
            end
            se  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc(rst, se, b);
        end
        cyc(0, 0, '0);

        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
